// File: rtl/sxafa_macro_ctrl_if.sv
// Host-side request/status and macro-side drive/sense signals of the SXAFA macro controller.
interface sxafa_macro_ctrl_if;
    // Host request / status
    logic           start;
    logic           op;
    logic [6:0]     row;
    logic           addr_sel;
    logic [63:0]    wdata;
    logic [127:0]   wl_mask;
    logic [127:0]   in_vec;
    logic           busy;
    logic           done;
    logic [63:0]    result;

    // Macro drive / sense
    logic           WE;
    logic [63:0]    BL;
    logic [63:0]    BLB;
    logic           Addr;
    logic [127:0]   WL;
    logic [127:0]   In_B;
    logic           wb;
    logic [63:0]    DOut;

    // Controller view
    modport slave (
        input  start, op, row, addr_sel, wdata, wl_mask, in_vec, DOut,
        output busy, done, result, WE, BL, BLB, Addr, WL, In_B, wb
    );

    // Host/macro-model view
    modport master (
        output start, op, row, addr_sel, wdata, wl_mask, in_vec, DOut,
        input  busy, done, result, WE, BL, BLB, Addr, WL, In_B, wb
    );
endinterface

// File: rtl/sxafa_macro_ctrl.sv
// Sequencer for one SXAFA macro: row write and masked compute with DOut capture.
module sxafa_macro_ctrl #(
    parameter int unsigned WR_CYC  = 2,
    parameter int unsigned CMP_LAT = 3
) (
    input  logic                   Clk,
    input  logic                   Rst,
    sxafa_macro_ctrl_if.slave      bus
);
    localparam int unsigned ROW_W  = 7;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned VEC_W  = 128;
    localparam int unsigned CNT_W  = 16;
    // A zero length would leave no drive cycle at all, so both phases last at least one cycle.
    localparam int unsigned WR_LEN  = (WR_CYC  == 0) ? 1 : WR_CYC;
    localparam int unsigned CMP_LEN = (CMP_LAT == 0) ? 1 : CMP_LAT;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_DRIVE  = 3'd1,
        WR_REL    = 3'd2,
        CMP_DRIVE = 3'd3,
        CMP_CAP   = 3'd4,
        DONE      = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Latched request
    logic [ROW_W-1:0]    row_q, row_d;
    logic                addr_sel_q, addr_sel_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [VEC_W-1:0]    wl_mask_q, wl_mask_d;
    logic [VEC_W-1:0]    in_vec_q, in_vec_d;

    // Registered outputs
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   bl_q, bl_d;
    logic [DATA_W-1:0]   blb_q, blb_d;
    logic                addr_q, addr_d;
    logic [VEC_W-1:0]    wl_q, wl_d;
    logic [VEC_W-1:0]    in_b_q, in_b_d;
    logic                wb_q, wb_d;

    // Next state, phase counter and request latch
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        addr_sel_d = addr_sel_q;
        wdata_d    = wdata_q;
        wl_mask_d  = wl_mask_q;
        in_vec_d   = in_vec_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    row_d      = bus.row;
                    addr_sel_d = bus.addr_sel;
                    wdata_d    = bus.wdata;
                    wl_mask_d  = bus.wl_mask;
                    in_vec_d   = bus.in_vec;
                    cnt_d      = '0;
                    state_d    = bus.op ? CMP_DRIVE : WR_DRIVE;
                end
            end
            WR_DRIVE: begin
                if (cnt_q == CNT_W'(WR_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = WR_REL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR_REL: state_d = DONE;
            CMP_DRIVE: begin
                if (cnt_q == CNT_W'(CMP_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = CMP_CAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CMP_CAP: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output values for the state being entered, so registered outputs line up with the state
    always_comb begin
        busy_d   = (state_d != IDLE);
        done_d   = 1'b0;
        result_d = result_q;
        we_d     = 1'b0;
        bl_d     = '1;
        blb_d    = '1;
        addr_d   = 1'b0;
        wl_d     = '0;
        in_b_d   = '0;
        wb_d     = 1'b0;

        case (state_d)
            WR_DRIVE: begin
                we_d   = 1'b1;
                wl_d   = VEC_W'(1) << row_d;
                bl_d   = wdata_d;
                blb_d  = ~wdata_d;
                addr_d = addr_sel_d;
            end
            WR_REL: begin
                addr_d = addr_sel_d;
            end
            CMP_DRIVE, CMP_CAP: begin
                wb_d   = 1'b1;
                wl_d   = wl_mask_d;
                in_b_d = in_vec_d;
                addr_d = addr_sel_d;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: ;
        endcase

        // DOut is sampled after CMP_LEN drive cycles; result then updates on entry to CMP_CAP
        if (state_q == CMP_DRIVE && state_d == CMP_CAP) begin
            result_d = bus.DOut;
        end
    end

    // State, latch and output registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            row_q      <= '0;
            addr_sel_q <= 1'b0;
            wdata_q    <= '0;
            wl_mask_q  <= '0;
            in_vec_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            we_q       <= 1'b0;
            bl_q       <= '1;
            blb_q      <= '1;
            addr_q     <= 1'b0;
            wl_q       <= '0;
            in_b_q     <= '0;
            wb_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            addr_sel_q <= addr_sel_d;
            wdata_q    <= wdata_d;
            wl_mask_q  <= wl_mask_d;
            in_vec_q   <= in_vec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            we_q       <= we_d;
            bl_q       <= bl_d;
            blb_q      <= blb_d;
            addr_q     <= addr_d;
            wl_q       <= wl_d;
            in_b_q     <= in_b_d;
            wb_q       <= wb_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.WE     = we_q;
    assign bus.BL     = bl_q;
    assign bus.BLB    = blb_q;
    assign bus.Addr   = addr_q;
    assign bus.WL     = wl_q;
    assign bus.In_B   = in_b_q;
    assign bus.wb     = wb_q;

endmodule

// File: tb/tb_sxafa_macro_ctrl.sv
// Directed bench for sxafa_macro_ctrl: default instance plus a CMP_LAT=0 instance.
module tb_sxafa_macro_ctrl;
    logic         Clk;
    logic         Rst;
    int           nvec;
    int           nerr;
    int           wbc0;
    int           wbc1;
    logic [63:0]  dout_val0;
    logic [63:0]  dout_val1;
    logic [63:0]  exp_result0;
    logic [127:0] exp_wl;
    logic [127:0] exp_in;
    logic [63:0]  exp_bl;

    sxafa_macro_ctrl_if bus0 ();
    sxafa_macro_ctrl_if bus1 ();

    sxafa_macro_ctrl #(.WR_CYC(2), .CMP_LAT(3)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus0)
    );

    sxafa_macro_ctrl #(.WR_CYC(2), .CMP_LAT(0)) dut_lat0 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Macro model: DOut carries the answer only in the last drive cycle before the sample point
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wbc0 <= 0;
            wbc1 <= 0;
        end else begin
            wbc0 <= bus0.wb ? wbc0 + 1 : 0;
            wbc1 <= bus1.wb ? wbc1 + 1 : 0;
        end
    end
    always_comb bus0.DOut = (bus0.wb && wbc0 == 2) ? dout_val0 : 64'h0BAD_F00D_0BAD_F00D;
    always_comb bus1.DOut = (bus1.wb && wbc1 == 0) ? dout_val1 : 64'h0BAD_F00D_0BAD_F00D;

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        bus0.start = 0; bus0.op = 0; bus0.row = '0; bus0.addr_sel = 0;
        bus0.wdata = '0; bus0.wl_mask = '0; bus0.in_vec = '0;
        bus1.start = 0; bus1.op = 0; bus1.row = '0; bus1.addr_sel = 0;
        bus1.wdata = '0; bus1.wl_mask = '0; bus1.in_vec = '0;
        dout_val0 = '0; dout_val1 = '0; exp_result0 = '0;
        #1 Rst = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            bus0.start = 1'($urandom); bus0.op = 1'($urandom); bus0.row = 7'($urandom);
            bus0.addr_sel = 1'($urandom); bus0.wdata = {$urandom, $urandom};
            bus0.wl_mask = {$urandom, $urandom, $urandom, $urandom};
            bus0.in_vec = {$urandom, $urandom, $urandom, $urandom};
        end
        #1;
        nvec++; if (bus0.busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %0b exp 0", bus0.busy); end
        nvec++; if (bus0.done !== 1'b0) begin nerr++; $display("FAIL rst_done: got %0b exp 0", bus0.done); end
        nvec++; if (bus0.result !== 64'h0) begin nerr++; $display("FAIL rst_result: got %h exp 0", bus0.result); end
        nvec++; if (bus0.WE !== 1'b0) begin nerr++; $display("FAIL rst_we: got %0b exp 0", bus0.WE); end
        nvec++; if (bus0.wb !== 1'b0) begin nerr++; $display("FAIL rst_wb: got %0b exp 0", bus0.wb); end
        nvec++; if (bus0.WL !== 128'h0) begin nerr++; $display("FAIL rst_wl: got %h exp 0", bus0.WL); end
        nvec++; if (bus0.In_B !== 128'h0) begin nerr++; $display("FAIL rst_inb: got %h exp 0", bus0.In_B); end
        nvec++; if (bus0.Addr !== 1'b0) begin nerr++; $display("FAIL rst_addr: got %0b exp 0", bus0.Addr); end
        nvec++; if (bus0.BL !== 64'hFFFF_FFFF_FFFF_FFFF) begin nerr++; $display("FAIL rst_bl: got %h exp all ones", bus0.BL); end
        nvec++; if (bus0.BLB !== 64'hFFFF_FFFF_FFFF_FFFF) begin nerr++; $display("FAIL rst_blb: got %h exp all ones", bus0.BLB); end
        // Release together with a start pulse: accepted on the first rising edge
        @(negedge Clk);
        Rst = 1'b1; bus0.start = 1; bus0.op = 0; bus0.row = 7'd3; bus0.addr_sel = 0;
        @(negedge Clk);
        bus0.start = 0;
        nvec++; if (bus0.busy !== 1'b1) begin nerr++; $display("FAIL rst_rel_busy: got %0b exp 1", bus0.busy); end
        nvec++; if (bus0.WE !== 1'b1) begin nerr++; $display("FAIL rst_rel_we: got %0b exp 1", bus0.WE); end
        cyc(4);
        nvec++; if (bus0.busy !== 1'b0) begin nerr++; $display("FAIL rst_rel_idle: got %0b exp 0", bus0.busy); end
        nvec++; if (bus0.result !== exp_result0) begin nerr++; $display("FAIL rst_rel_result: got %h exp %h", bus0.result, exp_result0); end
    endtask

    task automatic test_write();
        bus0.start = 1; bus0.op = 0; bus0.row = 7'd5; bus0.addr_sel = 1;
        bus0.wdata = 64'hA5A5_0000_FFFF_1234;
        bus0.wl_mask = {$urandom, $urandom, $urandom, $urandom};
        bus0.in_vec = {$urandom, $urandom, $urandom, $urandom};
        exp_wl = 128'h20;
        @(negedge Clk);
        // Scramble inputs: the macro must be driven from the latched copies
        bus0.start = 0; bus0.row = 7'd0; bus0.addr_sel = 0; bus0.wdata = 64'h0;
        nvec++; if (bus0.WE !== 1'b1) begin nerr++; $display("FAIL wr_we1: got %0b exp 1", bus0.WE); end
        nvec++; if (bus0.WL !== exp_wl) begin nerr++; $display("FAIL wr_wl1: got %h exp %h", bus0.WL, exp_wl); end
        nvec++; if (bus0.BL !== 64'hA5A5_0000_FFFF_1234) begin nerr++; $display("FAIL wr_bl: got %h exp a5a50000ffff1234", bus0.BL); end
        nvec++; if (bus0.BLB !== 64'h5A5A_FFFF_0000_EDCB) begin nerr++; $display("FAIL wr_blb: got %h exp 5a5affff0000edcb", bus0.BLB); end
        nvec++; if (bus0.wb !== 1'b0) begin nerr++; $display("FAIL wr_wb: got %0b exp 0", bus0.wb); end
        nvec++; if (bus0.Addr !== 1'b1) begin nerr++; $display("FAIL wr_addr: got %0b exp 1", bus0.Addr); end
        @(negedge Clk);
        nvec++; if (bus0.WE !== 1'b1 || bus0.WL !== exp_wl) begin nerr++; $display("FAIL wr_cyc2: got we=%0b wl=%h exp we=1 wl=%h", bus0.WE, bus0.WL, exp_wl); end
        @(negedge Clk);
        nvec++; if (bus0.WE !== 1'b0 || bus0.WL !== 128'h0) begin nerr++; $display("FAIL wr_rel: got we=%0b wl=%h exp we=0 wl=0", bus0.WE, bus0.WL); end
        nvec++; if (bus0.BL !== 64'hFFFF_FFFF_FFFF_FFFF || bus0.BLB !== 64'hFFFF_FFFF_FFFF_FFFF) begin nerr++; $display("FAIL wr_rel_pre: got bl=%h blb=%h exp all ones", bus0.BL, bus0.BLB); end
        nvec++; if (bus0.done !== 1'b0) begin nerr++; $display("FAIL wr_early_done: got %0b exp 0", bus0.done); end
        @(negedge Clk);
        nvec++; if (bus0.done !== 1'b1) begin nerr++; $display("FAIL wr_done: got %0b exp 1", bus0.done); end
        nvec++; if (bus0.result !== exp_result0) begin nerr++; $display("FAIL wr_result: got %h exp %h", bus0.result, exp_result0); end
        @(negedge Clk);
        nvec++; if (bus0.done !== 1'b0 || bus0.busy !== 1'b0) begin nerr++; $display("FAIL wr_idle: got done=%0b busy=%0b exp 0 0", bus0.done, bus0.busy); end
    endtask

    task automatic test_compute();
        exp_in = 128'h80FF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_F000;
        dout_val0 = 64'hDEAD_BEEF_0000_0001;
        bus0.start = 1; bus0.op = 1; bus0.addr_sel = 0;
        bus0.wl_mask = '1; bus0.in_vec = exp_in;
        @(negedge Clk);
        bus0.start = 0; bus0.wl_mask = '0; bus0.in_vec = '0;
        nvec++; if (bus0.wb !== 1'b1 || bus0.WE !== 1'b0) begin nerr++; $display("FAIL cmp_wb_we: got wb=%0b we=%0b exp 1 0", bus0.wb, bus0.WE); end
        nvec++; if (bus0.WL !== '1) begin nerr++; $display("FAIL cmp_wl: got %h exp all ones", bus0.WL); end
        nvec++; if (bus0.In_B !== exp_in) begin nerr++; $display("FAIL cmp_inb: got %h exp %h", bus0.In_B, exp_in); end
        nvec++; if (bus0.BL !== 64'hFFFF_FFFF_FFFF_FFFF || bus0.BLB !== 64'hFFFF_FFFF_FFFF_FFFF) begin nerr++; $display("FAIL cmp_bl: got bl=%h blb=%h exp all ones", bus0.BL, bus0.BLB); end
        cyc(2);
        nvec++; if (bus0.result !== exp_result0) begin nerr++; $display("FAIL cmp_early_result: got %h exp %h", bus0.result, exp_result0); end
        exp_result0 = 64'hDEAD_BEEF_0000_0001;
        @(negedge Clk);
        nvec++; if (bus0.result !== exp_result0) begin nerr++; $display("FAIL cmp_result: got %h exp %h", bus0.result, exp_result0); end
        nvec++; if (bus0.wb !== 1'b1 || bus0.In_B !== exp_in || bus0.done !== 1'b0) begin nerr++; $display("FAIL cmp_cap_hold: got wb=%0b done=%0b inb=%h", bus0.wb, bus0.done, bus0.In_B); end
        @(negedge Clk);
        nvec++; if (bus0.done !== 1'b1 || bus0.wb !== 1'b0 || bus0.In_B !== 128'h0) begin nerr++; $display("FAIL cmp_done: got done=%0b wb=%0b inb=%h exp 1 0 0", bus0.done, bus0.wb, bus0.In_B); end
        @(negedge Clk);
        nvec++; if (bus0.busy !== 1'b0 || bus0.WL !== 128'h0 || bus0.result !== exp_result0) begin nerr++; $display("FAIL cmp_idle: got busy=%0b wl=%h result=%h", bus0.busy, bus0.WL, bus0.result); end
    endtask

    task automatic test_ignored_start();
        int ndone;
        ndone = 0;
        dout_val0 = 64'h1234_5678_9ABC_DEF0;
        bus0.start = 1; bus0.op = 1; bus0.wl_mask = '1; bus0.in_vec = '1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge Clk);
            bus0.op = 0; bus0.row = 7'd9; bus0.wdata = 64'h0F0F_0F0F_0F0F_0F0F;
            if (bus0.done === 1'b1) ndone++;
            if (k == 6) begin
                exp_result0 = 64'h1234_5678_9ABC_DEF0;
                nvec++; if (bus0.busy !== 1'b0) begin nerr++; $display("FAIL ign_idle: got %0b exp 0", bus0.busy); end
                nvec++; if (bus0.result !== exp_result0) begin nerr++; $display("FAIL ign_result: got %h exp %h", bus0.result, exp_result0); end
            end
            if (k == 7) begin
                bus0.start = 0;
                exp_wl = 128'h200;
                nvec++; if (bus0.WE !== 1'b1 || bus0.WL !== exp_wl) begin nerr++; $display("FAIL ign_second: got we=%0b wl=%h exp we=1 wl=%h", bus0.WE, bus0.WL, exp_wl); end
            end
        end
        nvec++; if (ndone != 1) begin nerr++; $display("FAIL ign_ndone: got %0d exp 1", ndone); end
        cyc(3);
        nvec++; if (bus0.done !== 1'b1) begin nerr++; $display("FAIL ign_wr_done: got %0b exp 1", bus0.done); end
        @(negedge Clk);
    endtask

    task automatic test_mid_reset();
        int ndone;
        ndone = 0;
        bus0.start = 1; bus0.op = 0; bus0.row = 7'd7; bus0.wdata = {$urandom, $urandom};
        @(negedge Clk);
        bus0.start = 0;
        @(negedge Clk);
        nvec++; if (bus0.WE !== 1'b1) begin nerr++; $display("FAIL mr_we_before: got %0b exp 1", bus0.WE); end
        #2 Rst = 1'b0;
        #1;
        nvec++; if (bus0.WE !== 1'b0 || bus0.WL !== 128'h0) begin nerr++; $display("FAIL mr_async: got we=%0b wl=%h exp 0 0", bus0.WE, bus0.WL); end
        nvec++; if (bus0.busy !== 1'b0 || bus0.BL !== 64'hFFFF_FFFF_FFFF_FFFF) begin nerr++; $display("FAIL mr_state: got busy=%0b bl=%h", bus0.busy, bus0.BL); end
        exp_result0 = '0;
        dout_val0 = 64'h0000_1111_2222_3333;
        @(negedge Clk);
        Rst = 1'b1; bus0.start = 1; bus0.op = 1;
        @(negedge Clk);
        bus0.start = 0;
        nvec++; if (bus0.busy !== 1'b1 || bus0.wb !== 1'b1) begin nerr++; $display("FAIL mr_accept: got busy=%0b wb=%0b exp 1 1", bus0.busy, bus0.wb); end
        nvec++; if (bus0.result !== exp_result0) begin nerr++; $display("FAIL mr_result_clr: got %h exp %h", bus0.result, exp_result0); end
        for (int k = 0; k < 4; k++) begin
            if (bus0.done === 1'b1) ndone++;
            @(negedge Clk);
        end
        nvec++; if (ndone != 0) begin nerr++; $display("FAIL mr_no_done: got %0d done pulses exp 0", ndone); end
        nvec++; if (bus0.done !== 1'b1 || bus0.result !== 64'h0000_1111_2222_3333) begin nerr++; $display("FAIL mr_new_op: got done=%0b result=%h", bus0.done, bus0.result); end
        @(negedge Clk);
    endtask

    task automatic test_boundary();
        bus0.start = 1; bus0.op = 0; bus0.row = 7'd127; bus0.wdata = {$urandom, $urandom};
        exp_wl = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
        @(negedge Clk);
        bus0.start = 0;
        nvec++; if (bus0.WL !== exp_wl) begin nerr++; $display("FAIL bd_row127: got %h exp %h", bus0.WL, exp_wl); end
        cyc(4);
        bus0.start = 1; bus0.row = 7'd0;
        exp_wl = 128'h1;
        @(negedge Clk);
        bus0.start = 0;
        nvec++; if (bus0.WL !== exp_wl || bus0.WE !== 1'b1) begin nerr++; $display("FAIL bd_row0: got we=%0b wl=%h exp 1 %h", bus0.WE, bus0.WL, exp_wl); end
        cyc(4);
        exp_in = {$urandom, $urandom, $urandom, $urandom};
        dout_val1 = 64'hCAFE_F00D_1357_2468;
        bus1.start = 1; bus1.op = 1; bus1.wl_mask = '1; bus1.in_vec = exp_in;
        @(negedge Clk);
        bus1.start = 0;
        nvec++; if (bus1.wb !== 1'b1 || bus1.In_B !== exp_in) begin nerr++; $display("FAIL bd_lat0_drive: got wb=%0b inb=%h exp 1 %h", bus1.wb, bus1.In_B, exp_in); end
        @(negedge Clk);
        nvec++; if (bus1.result !== 64'hCAFE_F00D_1357_2468) begin nerr++; $display("FAIL bd_lat0_result: got %h exp cafef00d13572468", bus1.result); end
        @(negedge Clk);
        nvec++; if (bus1.done !== 1'b1) begin nerr++; $display("FAIL bd_lat0_done: got %0b exp 1", bus1.done); end
        @(negedge Clk);
        nvec++; if (bus1.busy !== 1'b0 || bus1.WE !== 1'b0) begin nerr++; $display("FAIL bd_lat0_idle: got busy=%0b we=%0b exp 0 0", bus1.busy, bus1.WE); end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_write();
        test_compute();
        test_ignored_start();
        test_mid_reset();
        test_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sxafa_macro_ctrl.md
SXAFA_MACRO_CTRL -- requirements
Module: sxafa_macro_ctrl

Interface
REQ-001 The block SHALL provide parameter WR_CYC, default 2, setting the number of cycles the write pulse (WE, WL) is held.
REQ-002 The block SHALL provide parameter CMP_LAT, default 3, setting the number of cycles from compute drive to DOut sample; a value of 0 SHALL behave as 1.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: operation request, accepted only in IDLE.
REQ-006 The block SHALL have port op, input, 1 bit: 0 selects write, 1 selects compute; sampled with start.
REQ-007 The block SHALL have port row, input, 7 bits: write row index, 0..127.
REQ-008 The block SHALL have port addr_sel, input, 1 bit: macro half select, forwarded to Addr.
REQ-009 The block SHALL have port wdata, input, 64 bits: write data for one row.
REQ-010 The block SHALL have port wl_mask, input, 128 bits: rows enabled during compute.
REQ-011 The block SHALL have port in_vec, input, 128 bits: compute input vector.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse at operation end.
REQ-014 The block SHALL have port result, output, 64 bits: the last captured DOut.
REQ-015 The block SHALL have port WE, output, 1 bit: macro write enable.
REQ-016 The block SHALL have ports BL and BLB, output, 64 bits each: macro bit-line pair.
REQ-017 The block SHALL have port Addr, output, 1 bit: macro address select.
REQ-018 The block SHALL have port WL, output, 128 bits: macro word lines.
REQ-019 The block SHALL have port In_B, output, 128 bits: macro input vector.
REQ-020 The block SHALL have port wb, output, 1 bit: macro compute/bit-line enable.
REQ-021 The block SHALL have port DOut, input, 64 bits: macro compute output.

Function
REQ-022 The FSM SHALL have the states IDLE, WR_DRIVE, WR_REL, CMP_DRIVE, CMP_CAP and DONE.
REQ-023 In IDLE, start=1 SHALL latch op, row, addr_sel, wdata, wl_mask and in_vec, then go to WR_DRIVE if op=0, or to CMP_DRIVE if op=1.
REQ-024 When start is accepted at edge N, every macro output SHALL be driven from the latched copies only, beginning at edge N+1.
REQ-025 WR_DRIVE SHALL last WR_CYC cycles, with WE=1, WL one-hot at bit row, BL=wdata, BLB=~wdata, Addr=addr_sel and wb=0.
REQ-026 WR_REL SHALL last 1 cycle, with WE=0, WL=0 and BL=BLB=all ones (precharge), then go to DONE.
REQ-027 CMP_DRIVE SHALL last CMP_LAT cycles, with WE=0, wb=1, WL=wl_mask, In_B=in_vec, BL=BLB=all ones and Addr=addr_sel.
REQ-028 CMP_CAP SHALL last 1 cycle: it SHALL register DOut into result, hold the drive values of REQ-027, then go to DONE.
REQ-029 DONE SHALL last 1 cycle, with done=1, WL=0, WE=0, wb=0 and In_B=0, then return to IDLE.
REQ-030 For a write, done SHALL be high in cycle N+WR_CYC+2; for a compute, in cycle N+CMP_LAT+2.
REQ-031 start SHALL be ignored while busy=1; it SHALL be re-sampled in IDLE, so back-to-back operations are possible one cycle after done.
REQ-032 result SHALL change only in CMP_CAP; a write operation SHALL leave result unchanged.
REQ-033 WE and wb SHALL never be high in the same cycle.
REQ-034 In IDLE, every macro output SHALL be 0, except BL and BLB, which SHALL be all ones.
REQ-035 WL SHALL have at most one bit set at any time while WE=1.

Reset
REQ-036 Rst=0 SHALL immediately force state IDLE, busy=0, done=0, result=0, WE=0, wb=0, WL=0, In_B=0, Addr=0 and BL=BLB=all ones, regardless of clock.
REQ-037 A reset asserted mid-operation SHALL abort that operation with no done pulse; after Rst returns to 1, the block SHALL accept start on the first rising edge.

Verification
REQ-038 Reset: hold Rst=0 for 3 cycles with random inputs -> all outputs equal the REQ-036 values; release, then pulse start -> busy=1 on the next cycle.
REQ-039 Write: op=0, row=5, wdata=64'hA5A5_0000_FFFF_1234 -> WE=1 and WL=1<<5 for 2 cycles, BLB=~BL, done in cycle N+4, result unchanged.
REQ-040 Compute: op=1, wl_mask=all ones, in_vec=128'h80FF..F000, with the model returning DOut=64'hDEAD_BEEF_0000_0001 -> result equals that value, with done in cycle N+5.
REQ-041 Ignored start: pulse start each cycle during a compute -> exactly one done, and the second operation is accepted only in the IDLE cycle after DONE.
REQ-042 Mid-operation reset: assert Rst=0 in the second WR_DRIVE cycle -> WE and WL drop without waiting for a clock edge, and no done pulse follows.
REQ-043 Boundary: write row=127, then row=0, then compute with CMP_LAT=0 -> WL[127] and then WL[0] are set, and the DOut sample is taken 1 cycle after drive.
